prog_loader: RTL

Boot-time program loader sitting directly upstream of the CPU and its unified memory. It receives a byte stream (length header, 16-bit words, optional checksum), writes the words into consecutive memory addresses, and holds the CPU in reset until the image is complete. When the load finishes it releases `cpu_reset`, and the CPU begins fetching from PC 0.

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader_word_assembler.sv | 38 +++
 rtl/prog_loader.sv | 138 +++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader: FSM state encoding, word-count
// width and state-class helpers used by the loader datapath.
package prog_loader_pkg;

    localparam int WCNT_W = 16;

    typedef logic [WCNT_W-1:0] wcnt_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

    function automatic logic rx_state(input state_e s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
    endfunction

    function automatic logic busy_state(input state_e s);
        return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CSUM};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// slave = loader side, master = byte source / memory side.
interface prog_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte pair to 16-bit word assembler; used for both the length
// header and the data words of the load stream.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_hi,
    input  logic       load_lo,
    input  logic [7:0] byte_in,
    output wcnt_t      word
);

    logic [7:0] hi_q, hi_d;
    logic [7:0] lo_q, lo_d;

    // NOTE: every always_comb output gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (load_hi) hi_d = byte_in;
        if (load_lo) lo_d = byte_in;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign word = {hi_q, lo_q};

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives length + big-endian words, writes them to
// consecutive memory addresses and holds the CPU in reset until the image is in.
// Optional trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         error
);

    state_e            state_q, state_d;
    wcnt_t             idx_q, idx_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    wcnt_t             len_word;
    wcnt_t             dat_word;
    wcnt_t             len_cand;
    logic              len_bad;
    logic              accept;
    logic              wr_active;
    logic [15:0]       wr_addr;
    logic [WCNT_W:0]   idx_next;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign wr_active = (state_q == S_WRITE);
    assign wr_addr   = BASE_ADDR + idx_q;
    assign idx_next  = {1'b0, idx_q} + 1'b1;

    word_assembler u_len (
        .clk     (clk),
        .reset   (reset),
        .load_hi (accept && state_q == S_LEN_HI),
        .load_lo (accept && state_q == S_LEN_LO),
        .byte_in (bus.rx_data),
        .word    (len_word)
    );

    word_assembler u_dat (
        .clk     (clk),
        .reset   (reset),
        .load_hi (accept && state_q == S_DATA_HI),
        .load_lo (accept && state_q == S_DATA_LO),
        .byte_in (bus.rx_data),
        .word    (dat_word)
    );

    // The low length byte is still on the bus when the range decision is made.
    assign len_cand = {len_word[15:8], bus.rx_data};
    assign len_bad  = (len_cand == '0) || (32'(len_cand) > MAX_WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start && (state_q inside {S_IDLE, S_DONE, S_ERROR}))
            csum_d = '0;
        else if (accept && (state_q inside {S_DATA_HI, S_DATA_LO}))
            csum_d = csum_q ^ bus.rx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
            S_LEN_HI:  if (accept) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    state_d = len_bad ? S_ERROR : S_DATA_HI;
                    idx_d   = '0;
                end
            end
            S_DATA_HI: if (accept) state_d = S_DATA_LO;
            S_DATA_LO: if (accept) state_d = S_WRITE;
            S_WRITE: begin
                addr_d  = wr_addr;
                wdata_d = dat_word;
                idx_d   = idx_next[WCNT_W-1:0];
                if (idx_next < {1'b0, len_word})
                    state_d = S_DATA_HI;
                else
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: if (accept) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Address/data are live during WRITE and hold the last written pair afterwards.
    assign bus.rx_ready  = rx_state(state_q);
    assign bus.mem_we    = wr_active;
    assign bus.mem_addr  = wr_active ? wr_addr  : addr_q;
    assign bus.mem_wdata = wr_active ? dat_word : wdata_q;

    assign cpu_reset = (state_q != S_DONE);
    assign busy      = busy_state(state_q);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);

endmodule
